data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32.
- MEM_ADDR_BITS, 8, log2 of the word count; default is 256 words, 1024 bytes.
- WAIT_CYCLES, 2, wait states inserted before each access; legal range 0-15.

REQ-002 The block SHALL have one clock and a synchronous, active-low reset. Ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on the rising edge.
- rst_n, in, 1, synchronous active-low reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, block can accept a request.
- req_we, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDRESS_WIDTH, byte address.
- req_wdata, in, DATA_WIDTH, write data.
- req_be, in, 4, byte enables; bit i enables byte i, bits 8i+7:8i.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, consumer accepts the response.
- rsp_rdata, out, DATA_WIDTH, read data; 0 for writes and for errors.
- rsp_err, out, 1, request was misaligned or out of range.

Function
REQ-003 The block SHALL contain 2^MEM_ADDR_BITS words of storage, indexed by req_addr[MEM_ADDR_BITS+1:2].
REQ-004 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-005 req_ready SHALL be 1 only in IDLE while rst_n is high; requests are never overlapped.
REQ-006 A request is accepted at a rising edge where req_valid and req_ready are both 1.
REQ-007 On acceptance, the block SHALL capture req_we, req_addr, req_wdata and req_be, load cnt with WAIT_CYCLES and go to WAIT.
REQ-008 In WAIT, if cnt != 0, the block SHALL decrement cnt and stay in WAIT.
REQ-009 In WAIT, if cnt == 0, the block SHALL perform the access, register rsp_rdata and rsp_err, and go to RESP.
REQ-010 rsp_valid SHALL be 1 exactly in RESP; the first response cycle follows the acceptance edge by WAIT_CYCLES+1 cycles.
REQ-011 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until an edge where rsp_ready is 1; the block then returns to IDLE.
REQ-012 The next request can be accepted no earlier than the edge after the response handshake.
REQ-013 req_valid and all request fields SHALL be ignored outside IDLE.
REQ-014 rsp_err SHALL be 1 when req_addr[1:0] != 0, or when any req_addr bit above MEM_ADDR_BITS+1 is set.
REQ-015 On an error, no storage SHALL be modified and rsp_rdata SHALL be 0.
REQ-016 On a write without error, only the bytes whose req_be bit is 1 SHALL be updated.
REQ-017 A write with req_be = 0000 SHALL leave storage unchanged, with rsp_err = 0 and rsp_rdata = 0.
REQ-018 A read without error SHALL return the full stored word, ignoring req_be.
REQ-019 A read of a word that has never been written returns unspecified data; benches SHALL NOT check it.
REQ-020 With WAIT_CYCLES = 0, the access SHALL occur at the edge after acceptance and rsp_valid SHALL rise one cycle after acceptance.

Reset
REQ-021 While rst_n is 0 at a rising edge, the block SHALL go to IDLE, clear cnt, and drive rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0.
REQ-022 req_ready SHALL be 0 while rst_n is 0, and SHALL be 1 in the first cycle after rst_n returns to 1.
REQ-023 Storage SHALL NOT be cleared by reset.
REQ-024 A reset before the access edge SHALL abort the request: no storage write and no response.
REQ-025 A reset during RESP SHALL discard the pending response.

Verification (WAIT_CYCLES = 2, MEM_ADDR_BITS = 8)
REQ-026 Write 0xDEADBEEF to 0x10 with be = 1111, then read 0x10 -> each rsp_valid rises 3 cycles after its acceptance; the read returns rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-027 Write 0x11223344 to 0x20 with be = 1111, then write 0xAABBCCDD to 0x20 with be = 0101, then read 0x20 -> rsp_rdata = 0x11BB33DD.
REQ-028 Read 0x22 -> rsp_err = 1, rsp_rdata = 0.
REQ-029 Write 0xFFFFFFFF to 0x400 -> rsp_err = 1; a subsequent read of 0x000, previously holding 0x00000000, still returns 0x00000000.
REQ-030 Hold rsp_ready = 0 for 5 cycles during a read response -> rsp_valid, rsp_rdata and rsp_err stay stable; req_ready = 0; req_valid pulses in that window are not accepted.
REQ-031 Word 0x30 holds 0x12345678; accept a write of 0x00000055 to 0x30, then pull rst_n low for one cycle at the next edge -> no response; req_ready = 1 after reset; a read of 0x30 returns 0x12345678.

Source files
------------

// File: rtl/data_mem_resp.sv
// Word-addressed data memory with a single outstanding request, a fixed
// number of wait states and a valid/ready response channel.
module data_mem_resp #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_ADDR_BITS = 8,
  parameter int unsigned WAIT_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [3:0]               req_be,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_d;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           cnt_d;
  logic                       access_c;

  logic                       q_we;
  logic [ADDRESS_WIDTH-1:0]   q_addr;
  logic [DATA_WIDTH-1:0]      q_wdata;
  logic [BE_W-1:0]            q_be;

  logic                       addr_err_c;
  logic [MEM_ADDR_BITS-1:0]   idx_c;

  logic [DATA_WIDTH-1:0]      mem [DEPTH];

  // Ready only in IDLE and never while reset is asserted
  assign req_ready = rst_n && (state == IDLE);

  // Word index and error decode from the captured address
  assign idx_c      = q_addr[MEM_ADDR_BITS+1:2];
  assign addr_err_c = (q_addr[1:0] != 2'b00) ||
                      ((q_addr >> (MEM_ADDR_BITS + 2)) != '0);

  // Next-state and wait-counter logic
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    access_c = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          access_c = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Capture the request fields at acceptance
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      q_we    <= req_we;
      q_addr  <= req_addr;
      q_wdata <= req_wdata;
      q_be    <= req_be;
    end
  end

  // Response registers: loaded on the access edge, held until handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (access_c) begin
      rsp_valid <= 1'b1;
      rsp_err   <= addr_err_c;
      rsp_rdata <= (!q_we && !addr_err_c) ? mem[idx_c] : '0;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Byte-masked storage write; storage is not touched by reset
  always_ff @(posedge clk) begin
    if (rst_n && access_c && q_we && !addr_err_c) begin
      for (int i = 0; i < BE_W; i++) begin
        if (q_be[i]) begin
          mem[idx_c][8*i +: 8] <= q_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp with a transaction-level reference model.
module tb_data_mem_resp;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned MAB = 8;
  localparam int unsigned WC  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  data_mem_resp #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_ADDR_BITS(MAB),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mem_m [256];
  logic [3:0]  wmask [256];
  bit          chk_en       = 1'b0;
  bit          busy         = 1'b0;
  bit          exp_active   = 1'b0;
  bit          exp_chk_data = 1'b0;
  int unsigned exp_due      = 0;
  int unsigned acc_cyc      = 0;
  logic [31:0] exp_rdata    = '0;
  logic        exp_err      = 1'b0;
  bit          pend_wr      = 1'b0;
  int unsigned pend_idx     = 0;
  logic [31:0] pend_data    = '0;
  logic [3:0]  pend_be      = '0;
  logic [31:0] last_rdata;
  logic        last_err;
  int unsigned last_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(rst_n && !busy));
      if (!exp_active || cyc < exp_due) begin
        chk("rsp_valid_low", 32'(rsp_valid), 32'd0);
      end else begin
        chk("rsp_valid_high", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        if (exp_chk_data) chk("rsp_rdata", rsp_rdata, exp_rdata);
      end
    end
  end

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    busy       = 1'b0;
    exp_active = 1'b0;
    pend_wr    = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  // Present a request and compute its expected response on acceptance
  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be);
    bit ok = 1'b0;
    bit err;
    int unsigned idx;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    busy      = 1'b1;
    acc_cyc   = cyc;
    exp_due   = cyc + WC + 1;
    err       = (addr % 4 != 0) || (addr >= 32'd1024);
    idx       = addr / 4;
    pend_wr   = 1'b0;
    exp_chk_data = 1'b1;
    exp_rdata = 32'd0;
    exp_err   = err;
    if (!err) begin
      if (we) begin
        pend_wr = 1'b1; pend_idx = idx; pend_data = wdata; pend_be = be;
      end else begin
        exp_rdata    = mem_m[idx];
        exp_chk_data = (wmask[idx] == 4'hF);
      end
    end
    exp_active = 1'b1;
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
    last_rdata = rsp_rdata;
    last_err   = rsp_err;
    last_lat   = cyc - acc_cyc;
  endtask

  // Wait for the response, optionally stall it, then complete the handshake
  task automatic resp(input int hold, input bit pulse);
    wait_valid();
    @(posedge clk);
    #1;
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
        req_valid = (i % 2) == 0;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready  = 1'b0;
    busy       = 1'b0;
    exp_active = 1'b0;
    if (pend_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (pend_be[b]) begin
          mem_m[pend_idx][8*b +: 8] = pend_data[8*b +: 8];
          wmask[pend_idx][b] = 1'b1;
        end
      end
      pend_wr = 1'b0;
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be);
    req(we, addr, wdata, be);
    resp(0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = '0;
      wmask[i] = '0;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);
    @(posedge clk);
    #1;

    // Full-word write then read back
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("wr10_lat", last_lat, 32'd3);
    chk("wr10_err", 32'(last_err), 32'd0);
    chk("wr10_rdata", last_rdata, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0);
    chk("rd10_lat", last_lat, 32'd3);
    chk("rd10_rdata", last_rdata, 32'hDEADBEEF);
    chk("rd10_err", 32'(last_err), 32'd0);

    // Partial byte-enable merge
    txn(1'b1, 32'h20, 32'h11223344, 4'hF);
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    txn(1'b0, 32'h20, 32'h0, 4'hF);
    chk("rd20_merge", last_rdata, 32'h11BB33DD);

    // Misaligned read
    txn(1'b0, 32'h22, 32'h0, 4'hF);
    chk("rd22_err", 32'(last_err), 32'd1);
    chk("rd22_rdata", last_rdata, 32'd0);

    // Out-of-range write leaves storage alone
    txn(1'b1, 32'h0, 32'h0, 4'hF);
    txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
    chk("wr400_err", 32'(last_err), 32'd1);
    txn(1'b0, 32'h0, 32'h0, 4'hF);
    chk("rd0_rdata", last_rdata, 32'd0);
    chk("rd0_err", 32'(last_err), 32'd0);

    // Stalled response with ignored request pulses
    req(1'b0, 32'h10, 32'h0, 4'h0);
    resp(5, 1'b1);
    chk("stall_rdata", last_rdata, 32'hDEADBEEF);
    txn(1'b0, 32'h10, 32'h0, 4'h0);
    chk("stall_after", last_rdata, 32'hDEADBEEF);

    // Reset after acceptance aborts the write
    txn(1'b1, 32'h30, 32'h12345678, 4'hF);
    req(1'b1, 32'h30, 32'h00000055, 4'hF);
    do_reset(1);
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    txn(1'b0, 32'h30, 32'h0, 4'hF);
    chk("rd30_abort", last_rdata, 32'h12345678);

    // Reset during RESP discards the response
    req(1'b0, 32'h30, 32'h0, 4'hF);
    wait_valid();
    @(posedge clk);
    #1;
    do_reset(1);
    repeat (5) @(posedge clk);
    #1;

    // Zero byte-enable write and misaligned write are both no-ops
    txn(1'b1, 32'h30, 32'hCAFEF00D, 4'h0);
    chk("be0_err", 32'(last_err), 32'd0);
    chk("be0_rdata", last_rdata, 32'd0);
    txn(1'b1, 32'h31, 32'hCAFEF00D, 4'hF);
    chk("wr31_err", 32'(last_err), 32'd1);
    txn(1'b0, 32'h30, 32'h0, 4'hF);
    chk("rd30_final", last_rdata, 32'h12345678);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
